// File: rtl/layer_sequence_controller.sv
// Per-layer sequencer: starts the MAC array, then pulses the activation load, and
// advances through NUM_LAYERS layers, with a watchdog and an abort path back to IDLE.
module layer_sequence_controller #(
    parameter int unsigned NUM_LAYERS     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 11
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic       mac_done_i,
    input  logic       act_done_i,
    output logic       mac_start_o,
    output logic       act_load_o,
    output logic [3:0] layer_sel_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_MAC_START, S_MAC_WAIT, S_ACT_LOAD, S_ACT_WAIT, S_FINISH, S_ERROR
    } state_t;

    localparam logic [3:0]       LAST_LAYER = 4'(NUM_LAYERS - 1);
    localparam logic [CNT_W-1:0] WDOG_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q;
    logic [CNT_W-1:0] wdog_q;
    logic [CNT_W-1:0] wdog_d;
    logic             mac_start_q, act_load_q, busy_q, done_q, error_q;
    logic [3:0]       layer_sel_q;
    logic             wdog_expired;

    assign wdog_d       = wdog_q + 1'b1;
    assign wdog_expired = (wdog_q == WDOG_LAST);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            wdog_q      <= '0;
            mac_start_q <= 1'b0;
            act_load_q  <= 1'b0;
            layer_sel_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a transition below re-arms them.
            mac_start_q <= 1'b0;
            act_load_q  <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE, S_ERROR: begin
                    if (start_i) begin
                        state_q     <= S_MAC_START;
                        layer_sel_q <= '0;
                        busy_q      <= 1'b1;
                        mac_start_q <= 1'b1;
                        error_q     <= 1'b0;
                    end else if (abort_i) begin
                        state_q <= S_IDLE;
                        error_q <= 1'b0;
                    end
                end
                S_MAC_START, S_ACT_LOAD: begin
                    if (abort_i) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        layer_sel_q <= '0;
                    end else begin
                        wdog_q  <= '0;
                        state_q <= (state_q == S_MAC_START) ? S_MAC_WAIT : S_ACT_WAIT;
                    end
                end
                S_MAC_WAIT, S_ACT_WAIT: begin
                    // Priority: abort, then the done strobe, then the watchdog.
                    if (abort_i) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        layer_sel_q <= '0;
                    end else if (state_q == S_MAC_WAIT && mac_done_i) begin
                        state_q    <= S_ACT_LOAD;
                        act_load_q <= 1'b1;
                    end else if (state_q == S_ACT_WAIT && act_done_i) begin
                        if (layer_sel_q == LAST_LAYER) begin
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q     <= S_MAC_START;
                            layer_sel_q <= layer_sel_q + 4'd1;
                            mac_start_q <= 1'b1;
                        end
                    end else if (wdog_expired) begin
                        state_q <= S_ERROR;
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        wdog_q <= wdog_d;
                    end
                end
                S_FINISH: state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    assign mac_start_o = mac_start_q;
    assign act_load_o  = act_load_q;
    assign layer_sel_o = layer_sel_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign error_o     = error_q;

endmodule

// File: tb/tb_layer_sequence_controller.sv
// Directed bench for layer_sequence_controller (NUM_LAYERS=2, TIMEOUT_CYCLES=16).
// Outputs are packed as {mac_start, act_load, layer_sel[3:0], busy, done, error}.
module tb_layer_sequence_controller;
    logic       clk = 1'b0;
    logic       reset, start, abort, mac_done, act_done;
    logic       mac_start, act_load, busy, done, error;
    logic [3:0] layer_sel;
    logic [8:0] outs;
    int         checks = 0;
    int         errors = 0;

    layer_sequence_controller #(.NUM_LAYERS(2), .TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
        .mac_done_i(mac_done), .act_done_i(act_done),
        .mac_start_o(mac_start), .act_load_o(act_load), .layer_sel_o(layer_sel),
        .busy_o(busy), .done_o(done), .error_o(error)
    );

    always #5 clk = ~clk;
    assign outs = {mac_start, act_load, layer_sel, busy, done, error};

    function automatic logic [8:0] o(input logic ms, input logic al, input logic [3:0] ls,
                                     input logic b, input logic d, input logic e);
        return {ms, al, ls, b, d, e};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; mac_done = 1'b0; act_done = 1'b0;
        tick(); tick();
        chk("reset", outs, o(0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        tick();
        chk("idle", outs, o(0, 0, 0, 0, 0, 0));

        // Full inference, mac_done 3 cycles after each mac_start.
        start = 1'b1; tick(); start = 1'b0;
        chk("t1 ms L0", outs, o(1, 0, 0, 1, 0, 0));
        for (int l = 0; l < 2; l++) begin
            tick();
            chk("t1 mwait", outs, o(0, 0, 4'(l), 1, 0, 0));
            tick(); tick(); mac_done = 1'b1;
            tick(); mac_done = 1'b0;
            chk("t1 act_load", outs, o(0, 1, 4'(l), 1, 0, 0));
            tick(); act_done = 1'b1;
            chk("t1 await", outs, o(0, 0, 4'(l), 1, 0, 0));
            tick(); act_done = 1'b0;
            if (l == 0) chk("t1 ms L1", outs, o(1, 0, 1, 1, 0, 0));
            else        chk("t1 done", outs, o(0, 0, 1, 0, 1, 0));
        end
        tick();
        chk("t1 done clr", {6'd0, busy, done, error}, 9'd0);

        // mac_done held high: MAC_START sample ignored, act_load 2 cycles after mac_start.
        mac_done = 1'b1; start = 1'b1; tick(); start = 1'b0;
        chk("t2 ms", outs, o(1, 0, 0, 1, 0, 0));
        tick();
        chk("t2 ignore", outs, o(0, 0, 0, 1, 0, 0));
        tick(); mac_done = 1'b0;
        chk("t2 act_load", outs, o(0, 1, 0, 1, 0, 0));
        tick();
        // abort together with act_done in ACT_WAIT of layer 0
        abort = 1'b1; act_done = 1'b1;
        tick(); abort = 1'b0; act_done = 1'b0;
        chk("t4 abort", outs, o(0, 0, 0, 0, 0, 0));
        tick();
        chk("t4 no restart", outs, o(0, 0, 0, 0, 0, 0));

        // Watchdog in MAC_WAIT.
        start = 1'b1; tick(); start = 1'b0;
        chk("t3 ms", outs, o(1, 0, 0, 1, 0, 0));
        repeat (16) tick();
        chk("t3 pre-timeout", outs, o(0, 0, 0, 1, 0, 0));
        tick();
        chk("t3 timeout", outs, o(0, 0, 0, 0, 0, 1));
        tick();
        chk("t3 sticky", outs, o(0, 0, 0, 0, 0, 1));
        start = 1'b1; tick(); start = 1'b0;
        chk("t3 restart", outs, o(1, 0, 0, 1, 0, 0));
        // done strobe in the final watchdog cycle wins
        repeat (16) tick();
        mac_done = 1'b1; tick(); mac_done = 1'b0;
        chk("t3 tie", outs, o(0, 1, 0, 1, 0, 0));
        tick(); // ACT_WAIT, watchdog restarted
        repeat (15) tick();
        chk("t3 act pre-timeout", outs, o(0, 0, 0, 1, 0, 0));
        tick();
        chk("t3 act timeout", outs, o(0, 0, 0, 0, 0, 1));
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t3 abort err", outs, o(0, 0, 0, 0, 0, 0));

        // Reset in MAC_WAIT of layer 1.
        start = 1'b1; tick(); start = 1'b0;
        tick(); mac_done = 1'b1;
        tick(); mac_done = 1'b0;
        tick(); act_done = 1'b1;
        tick(); act_done = 1'b0;
        tick();
        chk("t5 mwait L1", outs, o(0, 0, 1, 1, 0, 0));
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t5 reset", outs, o(0, 0, 0, 0, 0, 0));
        tick();
        chk("t5 idle", outs, o(0, 0, 0, 0, 0, 0));
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        chk("t5 restart", outs, o(1, 0, 0, 1, 0, 0));
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t5 abort", outs, o(0, 0, 0, 0, 0, 0));

        // Ideal strobes with spurious start while busy: done 9 cycles after start.
        start = 1'b1; tick(); start = 1'b0;
        chk("t6 ms L0", outs, o(1, 0, 0, 1, 0, 0));
        for (int l = 0; l < 2; l++) begin
            tick(); start = 1'b1; mac_done = 1'b1;
            tick(); start = 1'b0; mac_done = 1'b0;
            chk("t6 act_load", outs, o(0, 1, 4'(l), 1, 0, 0));
            tick(); act_done = 1'b1;
            chk("t6 await", outs, o(0, 0, 4'(l), 1, 0, 0));
            tick(); act_done = 1'b0;
            if (l == 0) chk("t6 ms L1", outs, o(1, 0, 1, 1, 0, 0));
            else        chk("t6 done", outs, o(0, 0, 1, 0, 1, 0));
        end
        tick();
        chk("t6 done clr", {6'd0, busy, done, error}, 9'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
